compas_memory_arbiter: RTL and testbench

COMPAS_MEMORY_ARBITER -- requirements
Module: compas_memory_arbiter

---
 rtl/compas_memory_arbiter_pkg.sv | 17 +
 rtl/compas_rr_arbiter2.sv | 39 +++
 rtl/compas_memory_arbiter.sv | 119 +++++++++++
 tb/tb_compas_memory_arbiter.sv | 270 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/compas_memory_arbiter_pkg.sv
// Shared defaults and types for the two-requester memory arbiter.
package compas_memory_arbiter_pkg;

  localparam int unsigned DEF_ADDR_W   = 14;
  localparam int unsigned DEF_DATA_W   = 32;
  localparam int unsigned DEF_NUMWORDS = 10000;

  typedef enum logic {
    REQ_M0 = 1'b0,
    REQ_M1 = 1'b1
  } req_idx_t;

  function automatic req_idx_t other_req(input req_idx_t idx);
    return (idx == REQ_M0) ? REQ_M1 : REQ_M0;
  endfunction

endpackage

// File: rtl/compas_rr_arbiter2.sv
// Two-way round-robin grant with last-grant pointer; grant is combinational.
module compas_rr_arbiter2
  import compas_memory_arbiter_pkg::*;
(
  input  logic       clk,
  input  logic       reset_n,
  input  logic [1:0] req_i,
  input  logic       block_i,
  output logic       gnt_valid_o,
  output req_idx_t   gnt_idx_o,
  output logic [1:0] gnt_o
);

  req_idx_t last_q;
  req_idx_t last_d;

  always_comb begin
    gnt_idx_o = REQ_M0;
    unique case (req_i)
      2'b11:   gnt_idx_o = other_req(last_q);
      2'b10:   gnt_idx_o = REQ_M1;
      default: gnt_idx_o = REQ_M0;
    endcase
    gnt_valid_o = (|req_i) & ~block_i;
    gnt_o       = {gnt_valid_o & (gnt_idx_o == REQ_M1),
                   gnt_valid_o & (gnt_idx_o == REQ_M0)};
    last_d      = gnt_valid_o ? gnt_idx_o : last_q;
  end

  // Pointer resets to m1 so that m0 wins the first tie.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      last_q <= REQ_M1;
    end else begin
      last_q <= last_d;
    end
  end

endmodule

// File: rtl/compas_memory_arbiter.sv
// Shares one single-port on-chip memory between two requesters: request mux,
// address range check and the fixed one-cycle read-return pipeline.
module compas_memory_arbiter
  import compas_memory_arbiter_pkg::*;
#(
  parameter int unsigned ADDR_W   = DEF_ADDR_W,
  parameter int unsigned DATA_W   = DEF_DATA_W,
  parameter int unsigned NUMWORDS = DEF_NUMWORDS
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  freeze,

  input  logic [ADDR_W-1:0]     m0_address,
  input  logic [DATA_W/8-1:0]   m0_byteenable,
  input  logic                  m0_read,
  input  logic                  m0_write,
  input  logic [DATA_W-1:0]     m0_writedata,
  output logic                  m0_waitrequest,
  output logic [DATA_W-1:0]     m0_readdata,
  output logic                  m0_readdatavalid,

  input  logic [ADDR_W-1:0]     m1_address,
  input  logic [DATA_W/8-1:0]   m1_byteenable,
  input  logic                  m1_read,
  input  logic                  m1_write,
  input  logic [DATA_W-1:0]     m1_writedata,
  output logic                  m1_waitrequest,
  output logic [DATA_W-1:0]     m1_readdata,
  output logic                  m1_readdatavalid,

  output logic [ADDR_W-1:0]     mem_address,
  output logic [DATA_W/8-1:0]   mem_byteenable,
  output logic                  mem_chipselect,
  output logic                  mem_write,
  output logic [DATA_W-1:0]     mem_writedata,
  output logic                  mem_clken,
  input  logic [DATA_W-1:0]     mem_readdata
);

  logic [1:0]          req;
  logic                gnt_valid;
  req_idx_t            gnt_idx;
  logic [1:0]          gnt;

  logic [ADDR_W-1:0]   sel_addr;
  logic [DATA_W/8-1:0] sel_be;
  logic [DATA_W-1:0]   sel_wdata;
  logic                sel_write;
  logic                sel_in_range;

  logic                rd_valid_q, rd_valid_d;
  req_idx_t            rd_owner_q, rd_owner_d;
  logic                rd_hit_q,   rd_hit_d;
  logic [DATA_W-1:0]   rd_data;

  assign req = {m1_read | m1_write, m0_read | m0_write};

  // Reset also blocks grants so waitrequest stays high while reset_n is low.
  compas_rr_arbiter2 u_arb (
    .clk         (clk),
    .reset_n     (reset_n),
    .req_i       (req),
    .block_i     (freeze | ~reset_n),
    .gnt_valid_o (gnt_valid),
    .gnt_idx_o   (gnt_idx),
    .gnt_o       (gnt)
  );

  always_comb begin
    sel_addr  = m0_address;
    sel_be    = m0_byteenable;
    sel_wdata = m0_writedata;
    sel_write = m0_write;
    if (gnt_idx == REQ_M1) begin
      sel_addr  = m1_address;
      sel_be    = m1_byteenable;
      sel_wdata = m1_writedata;
      sel_write = m1_write;
    end
    sel_in_range = 64'(sel_addr) < 64'(NUMWORDS);
  end

  assign m0_waitrequest = ~gnt[0];
  assign m1_waitrequest = ~gnt[1];

  // Out-of-range transfers are still granted but never reach the memory.
  assign mem_address    = sel_addr;
  assign mem_byteenable = sel_be;
  assign mem_writedata  = sel_wdata;
  assign mem_chipselect = gnt_valid & sel_in_range;
  assign mem_write      = gnt_valid & sel_in_range & sel_write;
  assign mem_clken      = reset_n;

  always_comb begin
    rd_valid_d = gnt_valid & ~sel_write;
    rd_owner_d = gnt_idx;
    rd_hit_d   = sel_in_range;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      rd_valid_q <= 1'b0;
      rd_owner_q <= REQ_M0;
      rd_hit_q   <= 1'b0;
    end else begin
      rd_valid_q <= rd_valid_d;
      rd_owner_q <= rd_owner_d;
      rd_hit_q   <= rd_hit_d;
    end
  end

  assign rd_data          = rd_hit_q ? mem_readdata : '0;
  assign m0_readdatavalid = rd_valid_q & (rd_owner_q == REQ_M0);
  assign m1_readdatavalid = rd_valid_q & (rd_owner_q == REQ_M1);
  assign m0_readdata      = m0_readdatavalid ? rd_data : '0;
  assign m1_readdata      = m1_readdatavalid ? rd_data : '0;

endmodule

// File: tb/tb_compas_memory_arbiter.sv
// Directed bench for compas_memory_arbiter with a behavioural 1-cycle SRAM
// and per-requester read-return scoreboards.
module tb_compas_memory_arbiter;

  localparam int unsigned AW = 14;
  localparam int unsigned DW = 32;
  localparam int unsigned NW = 10000;

  typedef struct {
    logic          rd;
    logic          wr;
    logic [AW-1:0] a;
    logic [3:0]    be;
    logic [31:0]   d;
  } mreq_t;

  typedef struct {
    logic [31:0] data;
    int unsigned due;
  } exp_t;

  logic clk = 1'b0;
  logic reset_n, freeze;
  logic [AW-1:0] m0_address, m1_address, mem_address;
  logic [3:0]    m0_byteenable, m1_byteenable, mem_byteenable;
  logic          m0_read, m0_write, m1_read, m1_write;
  logic [31:0]   m0_writedata, m1_writedata, mem_writedata;
  logic          m0_waitrequest, m1_waitrequest;
  logic [31:0]   m0_readdata, m1_readdata, mem_readdata;
  logic          m0_readdatavalid, m1_readdatavalid;
  logic          mem_chipselect, mem_write, mem_clken;

  int unsigned n_cmp  = 0;
  int unsigned n_fail = 0;
  int unsigned cyc    = 0;

  exp_t        sb [2][$];
  logic [31:0] ref_mem [int unsigned];
  logic [31:0] env_mem [int unsigned];

  always #5 clk = ~clk;

  compas_memory_arbiter #(.ADDR_W(AW), .DATA_W(DW), .NUMWORDS(NW)) dut (
    .clk(clk), .reset_n(reset_n), .freeze(freeze),
    .m0_address(m0_address), .m0_byteenable(m0_byteenable), .m0_read(m0_read),
    .m0_write(m0_write), .m0_writedata(m0_writedata), .m0_waitrequest(m0_waitrequest),
    .m0_readdata(m0_readdata), .m0_readdatavalid(m0_readdatavalid),
    .m1_address(m1_address), .m1_byteenable(m1_byteenable), .m1_read(m1_read),
    .m1_write(m1_write), .m1_writedata(m1_writedata), .m1_waitrequest(m1_waitrequest),
    .m1_readdata(m1_readdata), .m1_readdatavalid(m1_readdatavalid),
    .mem_address(mem_address), .mem_byteenable(mem_byteenable),
    .mem_chipselect(mem_chipselect), .mem_write(mem_write),
    .mem_writedata(mem_writedata), .mem_clken(mem_clken), .mem_readdata(mem_readdata)
  );

  function automatic logic [31:0] pat(input logic [AW-1:0] a);
    return 32'hC0DE_0000 ^ {18'b0, a};
  endfunction

  // Behavioural synchronous SRAM; unwritten words hold an address pattern.
  always @(posedge clk) begin
    logic [31:0] w;
    if (mem_clken && mem_chipselect) begin
      w = env_mem.exists(32'(mem_address)) ? env_mem[32'(mem_address)] : pat(mem_address);
      if (mem_write) begin
        for (int b = 0; b < 4; b++)
          if (mem_byteenable[b]) w[b*8 +: 8] = mem_writedata[b*8 +: 8];
        env_mem[32'(mem_address)] = w;
      end else begin
        mem_readdata <= w;
      end
    end
  end

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic mon(input int k, input logic v, input logic [31:0] d);
    exp_t e;
    if (v) begin
      if (sb[k].size() == 0) begin
        chk($sformatf("m%0d_spurious_valid", k), 32'(v), 32'd0);
      end else begin
        e = sb[k].pop_front();
        chk($sformatf("m%0d_valid_cycle", k), cyc, e.due);
        chk($sformatf("m%0d_readdata", k), d, e.data);
      end
    end else begin
      if (sb[k].size() > 0 && sb[k][0].due <= cyc) begin
        chk($sformatf("m%0d_missing_valid", k), 32'(v), 32'd1);
        void'(sb[k].pop_front());
      end
      chk($sformatf("m%0d_idle_readdata", k), d, 32'd0);
    end
  endtask

  always @(negedge clk) begin
    if (reset_n) begin
      mon(0, m0_readdatavalid, m0_readdata);
      mon(1, m1_readdatavalid, m1_readdata);
    end
  end

  function automatic mreq_t IDLE();
    mreq_t q;
    q.rd = 1'b0; q.wr = 1'b0; q.a = '0; q.be = '0; q.d = '0;
    return q;
  endfunction

  function automatic mreq_t RD(input int unsigned a);
    mreq_t q;
    q = IDLE();
    q.rd = 1'b1; q.a = AW'(a); q.be = 4'hF;
    return q;
  endfunction

  function automatic mreq_t WR(input int unsigned a, input logic [3:0] be, input logic [31:0] d);
    mreq_t q;
    q = IDLE();
    q.wr = 1'b1; q.a = AW'(a); q.be = be; q.d = d;
    return q;
  endfunction

  task automatic drive(input mreq_t q0, input mreq_t q1, input logic frz);
    m0_read = q0.rd; m0_write = q0.wr; m0_address = q0.a; m0_byteenable = q0.be; m0_writedata = q0.d;
    m1_read = q1.rd; m1_write = q1.wr; m1_address = q1.a; m1_byteenable = q1.be; m1_writedata = q1.d;
    freeze = frz;
  endtask

  // One cycle: drive at posedge+1, check grant at negedge, end at next posedge+1.
  // g: 0 = no grant expected, 1 = m0, 2 = m1.
  task automatic step(input mreq_t q0, input mreq_t q1, input logic frz, input int g);
    mreq_t       sel;
    logic        inr;
    logic [31:0] w;
    exp_t        e;
    drive(q0, q1, frz);
    @(negedge clk);
    chk("m0_waitrequest", 32'(m0_waitrequest), 32'(g != 1));
    chk("m1_waitrequest", 32'(m1_waitrequest), 32'(g != 2));
    if (g == 0) begin
      chk("idle_chipselect", 32'(mem_chipselect), 32'd0);
      chk("idle_mem_write", 32'(mem_write), 32'd0);
    end else begin
      sel = (g == 1) ? q0 : q1;
      inr = 32'(sel.a) < NW;
      chk("chipselect", 32'(mem_chipselect), 32'(inr));
      if (inr) begin
        chk("mem_address", 32'(mem_address), 32'(sel.a));
        chk("mem_write", 32'(mem_write), 32'(sel.wr));
        if (sel.wr) begin
          chk("mem_writedata", mem_writedata, sel.d);
          chk("mem_byteenable", 32'(mem_byteenable), 32'(sel.be));
        end
      end
      if (sel.wr) begin
        if (inr) begin
          w = ref_mem.exists(32'(sel.a)) ? ref_mem[32'(sel.a)] : pat(sel.a);
          for (int b = 0; b < 4; b++)
            if (sel.be[b]) w[b*8 +: 8] = sel.d[b*8 +: 8];
          ref_mem[32'(sel.a)] = w;
        end
      end else begin
        e.data = !inr ? 32'd0 :
                 ref_mem.exists(32'(sel.a)) ? ref_mem[32'(sel.a)] : pat(sel.a);
        e.due  = cyc + 1;
        sb[g-1].push_back(e);
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic chk_reset_state(input string tag);
    chk({tag, "_wr0"}, 32'(m0_waitrequest), 32'd1);
    chk({tag, "_wr1"}, 32'(m1_waitrequest), 32'd1);
    chk({tag, "_cs"}, 32'(mem_chipselect), 32'd0);
    chk({tag, "_memwr"}, 32'(mem_write), 32'd0);
    chk({tag, "_clken"}, 32'(mem_clken), 32'd0);
    chk({tag, "_rv0"}, 32'(m0_readdatavalid), 32'd0);
    chk({tag, "_rv1"}, 32'(m1_readdatavalid), 32'd0);
  endtask

  initial begin
    reset_n = 1'b0;
    drive(RD(1), WR(2, 4'hF, 32'h1), 1'b0);
    repeat (2) @(posedge clk);
    #1;
    chk_reset_state("reset");
    drive(IDLE(), IDLE(), 1'b0);
    reset_n = 1'b1;
    #1;
    chk("clken_after_reset", 32'(mem_clken), 32'd1);

    // Contention straight out of reset: m0 first, then strict alternation.
    for (int i = 0; i < 8; i++)
      step(RD(100 + i), RD(200 + i), 1'b0, (i % 2 == 0) ? 1 : 2);
    step(IDLE(), IDLE(), 1'b0, 0);

    // Single requester write then read, no wait states.
    step(WR(5, 4'hF, 32'hA5A5_A5A5), IDLE(), 1'b0, 1);
    step(RD(5), IDLE(), 1'b0, 1);
    step(IDLE(), IDLE(), 1'b0, 0);

    // Byte lanes.
    step(IDLE(), WR(7, 4'hF, 32'h1122_3344), 1'b0, 2);
    step(IDLE(), WR(7, 4'h2, 32'hFFFF_FFFF), 1'b0, 2);
    step(IDLE(), RD(7), 1'b0, 2);
    step(IDLE(), IDLE(), 1'b0, 0);

    // Out of range and last in-range word.
    step(IDLE(), WR(NW, 4'hF, 32'hDEAD_BEEF), 1'b0, 2);
    step(IDLE(), RD(NW), 1'b0, 2);
    step(WR(NW - 1, 4'hF, 32'h0BAD_F00D), IDLE(), 1'b0, 1);
    step(RD(NW - 1), IDLE(), 1'b0, 1);
    step(IDLE(), IDLE(), 1'b0, 0);

    // Both-high is a write.
    step(IDLE(), RD(0), 1'b0, 2);
    begin
      mreq_t q;
      q = WR(9, 4'hF, 32'h5555_AAAA);
      q.rd = 1'b1;
      step(q, IDLE(), 1'b0, 1);
    end
    step(RD(9), IDLE(), 1'b0, 1);

    // Freeze after a granted read; pointer (m0) survives the freeze.
    step(RD(300), RD(301), 1'b0, 2);
    step(RD(300), RD(301), 1'b0, 1);
    for (int i = 0; i < 3; i++)
      step(RD(302), RD(303), 1'b1, 0);
    step(RD(302), RD(303), 1'b0, 2);
    step(RD(302), RD(304), 1'b0, 1);
    step(IDLE(), IDLE(), 1'b0, 0);

    // Reset in the cycle after a read grant kills the return.
    step(RD(400), RD(401), 1'b0, 2);
    step(RD(402), IDLE(), 1'b0, 1);
    reset_n = 1'b0;
    sb[0].delete();
    sb[1].delete();
    drive(IDLE(), IDLE(), 1'b0);
    #1;
    chk_reset_state("reset_midread");
    @(negedge clk);
    chk("midread_rv0", 32'(m0_readdatavalid), 32'd0);
    @(posedge clk);
    #1;
    reset_n = 1'b1;
    step(RD(410), RD(411), 1'b0, 1);
    step(RD(412), RD(411), 1'b0, 2);
    step(IDLE(), IDLE(), 1'b0, 0);
    step(IDLE(), IDLE(), 1'b0, 0);

    chk("sb0_drained", sb[0].size(), 32'd0);
    chk("sb1_drained", sb[1].size(), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
